// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - operand/result handshake and full-adder loop signals
interface serial_add_sequencer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, op_a, op_b, cin_in, fa_s, fa_cout,
    input  fa_a, fa_b, fa_cin, sum, cout, busy, done
  );

  modport slave (
    input  start, op_a, op_b, cin_in, fa_s, fa_cout,
    output fa_a, fa_b, fa_cin, sum, cout, busy, done
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add sequencer around an external full adder
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   s_shift;

  // Slicing the widened vector keeps the shift legal when WIDTH is 1.
  assign s_shift = {bus.fa_s, s_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.op_a;
            b_sr  <= bus.op_b;
            carry <= bus.cin_in;
            cnt   <= '0;
            s_sr  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_sr  <= s_shift[WIDTH:1];
          carry <= bus.fa_cout;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= FIN;
            bus.sum  <= s_shift[WIDTH:1];
            bus.cout <= bus.fa_cout;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Adder inputs come straight from registers so the external loop stays acyclic.
  assign bus.fa_a   = (state == RUN) & a_sr[0];
  assign bus.fa_b   = (state == RUN) & b_sr[0];
  assign bus.fa_cin = (state == RUN) & carry;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == FIN);
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - randomized and directed checks against a reference adder model
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(W)) i8 ();
  serial_add_sequencer_if #(.WIDTH(1)) i1 ();

  serial_add_sequencer #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  assign i8.fa_s    = i8.fa_a ^ i8.fa_b ^ i8.fa_cin;
  assign i8.fa_cout = (i8.fa_a & i8.fa_b) | (i8.fa_cin & (i8.fa_a ^ i8.fa_b));
  assign i1.fa_s    = i1.fa_a ^ i1.fa_b ^ i1.fa_cin;
  assign i1.fa_cout = (i1.fa_a & i1.fa_b) | (i1.fa_cin & (i1.fa_a ^ i1.fa_b));

  int n_tests = 0;
  int n_fail  = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: phase counts cycles since acceptance; results come from plain addition.
  int          phase = -1;
  logic [31:0] ma = '0, mb = '0;
  logic        mc = 1'b0;
  logic [8:0]  exp_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= -1;
      exp_res <= '0;
    end else if (phase < 0) begin
      if (i8.start) begin
        ma    <= {24'b0, i8.op_a};
        mb    <= {24'b0, i8.op_b};
        mc    <= i8.cin_in;
        phase <= 0;
      end
    end else if (phase == W) begin
      phase <= -1;
    end else begin
      phase <= phase + 1;
      if (phase == W - 1) exp_res <= 9'(ma + mb + {31'b0, mc});
    end
  end

  logic [63:0] mask, partial;
  logic        e_busy, e_done, e_a, e_b, e_c;
  always @(negedge clk) begin
    if (en) begin
      e_busy = (phase >= 0);
      e_done = (phase == W);
      e_a = 1'b0; e_b = 1'b0; e_c = 1'b0;
      if (phase >= 0 && phase < W) begin
        mask    = (64'd1 << phase) - 64'd1;
        partial = ({32'b0, ma} & mask) + ({32'b0, mb} & mask) + {63'b0, mc};
        e_a = ma[phase];
        e_b = mb[phase];
        e_c = partial[phase];
      end
      chk("busy", {63'b0, i8.busy}, {63'b0, e_busy});
      chk("done", {63'b0, i8.done}, {63'b0, e_done});
      chk("fa_abc", {61'b0, i8.fa_a, i8.fa_b, i8.fa_cin}, {61'b0, e_a, e_b, e_c});
      chk("cout_sum", {55'b0, i8.cout, i8.sum}, {55'b0, exp_res});
    end
  end

  logic [8:0] done_q[$];
  logic [1:0] done1_q[$];
  always @(negedge clk) begin
    if (i8.done) done_q.push_back({i8.cout, i8.sum});
    if (i1.done) done1_q.push_back({i1.cout, i1.sum});
  end

  logic [7:0] fa_a_seq, fa_cin_seq;

  // Called at posedge+2 with the DUT idle; returns at posedge+2 with the DUT idle again.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    bit got = 0;
    int bitn = 0;
    lat = 0;
    fa_a_seq = '0; fa_cin_seq = '0;
    i8.op_a = a; i8.op_b = b; i8.cin_in = c; i8.start = 1'b1;
    @(posedge clk); #2;
    i8.start = 1'b0; i8.op_a = 8'($urandom); i8.op_b = 8'($urandom); i8.cin_in = 1'($urandom);
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (i8.busy && !i8.done && bitn < 8) begin
        fa_a_seq[bitn]   = i8.fa_a;
        fa_cin_seq[bitn] = i8.fa_cin;
        bitn++;
      end
      if (i8.done) begin got = 1; lat = n; end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
  endtask

  task automatic op1(input logic a, input logic b, input logic c, output int lat);
    bit got = 0;
    lat = 0;
    i1.op_a = a; i1.op_b = b; i1.cin_in = c; i1.start = 1'b1;
    @(posedge clk); #2;
    i1.start = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (i1.done) begin got = 1; lat = n; end
    end
    if (!got) chk("done1_timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
  endtask

  function automatic logic [63:0] last8();
    return (done_q.size() > 0) ? {55'b0, done_q[$]} : 64'hDEAD;
  endfunction

  initial begin
    int lat, q0;
    logic [7:0] a, b;
    logic c;
    i8.start = 0; i8.op_a = '0; i8.op_b = '0; i8.cin_in = 0;
    i1.start = 0; i1.op_a = '0; i1.op_b = '0; i1.cin_in = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_busy", {63'b0, i8.busy}, 64'd0);
    chk("rst_done", {63'b0, i8.done}, 64'd0);
    chk("rst_sum", {55'b0, i8.cout, i8.sum}, 64'd0);
    chk("rst_fa", {61'b0, i8.fa_a, i8.fa_b, i8.fa_cin}, 64'd0);
    en = 1'b1;
    @(posedge clk); #2;

    op8(8'h5A, 8'h3C, 1'b0, lat);
    chk("lat_5a", 64'(lat), 64'd9);
    chk("sum_5a", last8(), 64'h096);
    chk("fa_a_seq", {56'b0, fa_a_seq}, 64'h5A);

    op8(8'hFF, 8'h01, 1'b0, lat);
    chk("sum_ff01", last8(), 64'h100);
    chk("fa_cin_seq", {56'b0, fa_cin_seq}, 64'hFE);

    op8(8'hFF, 8'hFF, 1'b1, lat);
    chk("sum_ffff1", last8(), 64'h1FF);

    // START held high through RUN/FIN: second op is taken at the first IDLE edge.
    q0 = done_q.size();
    i8.op_a = 8'h10; i8.op_b = 8'h20; i8.cin_in = 0; i8.start = 1'b1;
    @(posedge clk); #2;
    i8.op_a = 8'h33; i8.op_b = 8'h44;
    repeat (W + 2) @(posedge clk);
    #2 i8.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("hold_dones", 64'(done_q.size() - q0), 64'd2);
    if (done_q.size() >= q0 + 2) begin
      chk("hold_first", {55'b0, done_q[q0]}, 64'h030);
      chk("hold_second", {55'b0, done_q[q0 + 1]}, 64'h077);
    end
    @(posedge clk); #2;

    // Reset mid-operation while bit 4 is on the adder.
    q0 = done_q.size();
    i8.op_a = 8'h21; i8.op_b = 8'h42; i8.start = 1'b1;
    @(posedge clk); #2;
    i8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'b0, i8.busy}, 64'd0);
    chk("arst_sum", {55'b0, i8.cout, i8.sum}, 64'd0);
    chk("arst_fa", {61'b0, i8.fa_a, i8.fa_b, i8.fa_cin}, 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("arst_no_done", 64'(done_q.size() - q0), 64'd0);
    @(posedge clk); #2;

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      if (i % 8 == 0) begin a = 8'hFF; b = 8'($urandom_range(0, 1)); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      op8(a, b, c, lat);
      chk("rand_lat", 64'(lat), 64'd9);
      chk("rand_sum", last8(), 64'(9'({1'b0, a} + {1'b0, b} + {8'b0, c})));
    end

    op1(1'b1, 1'b1, 1'b1, lat);
    chk("w1_lat", 64'(lat), 64'd2);
    chk("w1_sum", (done1_q.size() > 0) ? {62'b0, done1_q[$]} : 64'hDEAD, 64'h3);
    for (int i = 0; i < 8; i++) begin
      op1(i[0], i[1], i[2], lat);
      chk("w1_rand_lat", 64'(lat), 64'd2);
      chk("w1_rand_sum", (done1_q.size() > 0) ? {62'b0, done1_q[$]} : 64'hDEAD,
          64'(i[0]) + 64'(i[1]) + 64'(i[2]));
    end

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failed %0d", n_fail + 1);
    $fatal(1);
  end
endmodule
